display_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between two producers: keypad entry echo (port A) and computed results (port B). The block owns the 16-bit value the display multiplexer shows, drives its `d3..d0` inputs, and grants producers over a request/grant handshake. After each result load it locks the display for a programmable hold time, so the result stays readable.

---
 rtl/display_arbiter_if.sv | 26 ++
 rtl/display_arbiter.sv | 80 ++++++++
 tb/tb_display_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// Handshake and display bundle between the two producers and the display arbiter.
// The master side is the producers (keypad echo, result); the slave side is the arbiter.
interface display_arbiter_if;
  logic        clear;
  logic        req_a;
  logic [15:0] data_a;
  logic        gnt_a;
  logic        req_b;
  logic [15:0] data_b;
  logic        gnt_b;
  logic [3:0]  d3;
  logic [3:0]  d2;
  logic [3:0]  d1;
  logic [3:0]  d0;
  logic        busy;

  modport master (
    output clear, req_a, data_a, req_b, data_b,
    input  gnt_a, gnt_b, d3, d2, d1, d0, busy
  );

  modport slave (
    input  clear, req_a, data_a, req_b, data_b,
    output gnt_a, gnt_b, d3, d2, d1, d0, busy
  );
endinterface

// File: rtl/display_arbiter.sv
// Owns the 4-digit display value and arbitrates keypad echo (A) against results (B).
// A result load locks the display for HOLD_CYCLES cycles so it stays readable.
module display_arbiter #(
  parameter int HOLD_CYCLES = 27000000
) (
  input  logic              clk,
  input  logic              rst_n,
  display_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      disp_reg, disp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             gnt_a_raw, gnt_b_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      disp_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      disp_reg  <= disp_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Priority is clear > B > A; A is never eligible while the result is locked.
  always_comb begin
    state_next = state_reg;
    disp_next  = disp_reg;
    cnt_next   = cnt_reg;
    gnt_a_raw  = 1'b0;
    gnt_b_raw  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.clear) begin
          disp_next = '0;
        end else if (bus.req_b) begin
          gnt_b_raw  = 1'b1;
          disp_next  = bus.data_b;
          cnt_next   = '0;
          state_next = HOLD;
        end else if (bus.req_a) begin
          gnt_a_raw = 1'b1;
          disp_next = bus.data_a;
        end
      end
      HOLD: begin
        if (bus.clear) begin
          disp_next  = '0;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (bus.req_b) begin
          gnt_b_raw = 1'b1;
          disp_next = bus.data_b;
          cnt_next  = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants are combinational, so they must also be forced low while reset is held.
  assign bus.gnt_a = gnt_a_raw & rst_n;
  assign bus.gnt_b = gnt_b_raw & rst_n;
  assign bus.busy  = (state_reg == HOLD);
  assign bus.d3    = disp_reg[15:12];
  assign bus.d2    = disp_reg[11:8];
  assign bus.d1    = disp_reg[7:4];
  assign bus.d0    = disp_reg[3:0];
endmodule

// File: tb/tb_display_arbiter.sv
// Randomized and directed check of display_arbiter against a cycle-count model of
// the display lock: remaining hold cycles and the shown value.
module tb_display_arbiter;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_arbiter_if bus ();

  display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: value on the display and number of locked cycles still to come.
  logic [15:0] m_disp = '0;
  int          m_hold = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a rising edge with inputs driven; checks mid-cycle and
  // advances the model across the next edge. A granted producer drops its request.
  task automatic step();
    logic exp_ga, exp_gb;
    @(negedge clk);
    exp_ga = 1'b0;
    exp_gb = 1'b0;
    if (!bus.clear) begin
      if (bus.req_b)                    exp_gb = 1'b1;
      else if (bus.req_a && m_hold == 0) exp_ga = 1'b1;
    end
    check("gnt_a", 16'(bus.gnt_a), 16'(exp_ga));
    check("gnt_b", 16'(bus.gnt_b), 16'(exp_gb));
    check("busy",  16'(bus.busy),  16'(m_hold > 0));
    check("digits", {bus.d3, bus.d2, bus.d1, bus.d0}, m_disp);
    $display("cyc t=%0t clr=%b ra=%b rb=%b ga=%b gb=%b busy=%b disp=%h",
             $time, bus.clear, bus.req_a, bus.req_b, bus.gnt_a, bus.gnt_b, bus.busy,
             {bus.d3, bus.d2, bus.d1, bus.d0});
    if (bus.clear) begin
      m_disp = '0;
      m_hold = 0;
    end else if (exp_gb) begin
      m_disp = bus.data_b;
      m_hold = HOLD;
    end else if (exp_ga) begin
      m_disp = bus.data_a;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
    @(posedge clk);
    #1;
    if (exp_ga) bus.req_a = 1'b0;
    if (exp_gb) bus.req_b = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt_a"}, 16'(bus.gnt_a), 16'h0);
    check({tag, "_gnt_b"}, 16'(bus.gnt_b), 16'h0);
    check({tag, "_busy"},  16'(bus.busy),  16'h0);
    check({tag, "_digits"}, {bus.d3, bus.d2, bus.d1, bus.d0}, 16'h0000);
  endtask

  initial begin
    bus.clear  = 1'b0;
    bus.req_a  = 1'b1;
    bus.data_a = 16'h1234;
    bus.req_b  = 1'b0;
    bus.data_b = 16'h0000;

    // Reset held with A requesting: nothing granted, display blank.
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    steps(2);

    // B lock with A held throughout, and simultaneous A/B in IDLE.
    bus.req_a = 1'b1; bus.data_a = 16'h0007;
    bus.req_b = 1'b1; bus.data_b = 16'h0042;
    steps(8);

    // Hold restart by a second B load at t+3.
    bus.req_b = 1'b1; bus.data_b = 16'h0042;
    steps(3);
    bus.req_b = 1'b1; bus.data_b = 16'h0099;
    steps(7);

    // Clear during HOLD while B is requesting.
    bus.req_b = 1'b1; bus.data_b = 16'h0055;
    steps(2);
    bus.clear = 1'b1; bus.req_b = 1'b1; bus.data_b = 16'h0066;
    step();
    bus.clear = 1'b0;
    steps(6);

    // Asynchronous reset mid-HOLD, applied between clock edges.
    bus.req_b = 1'b1; bus.data_b = 16'h0777;
    steps(2);
    bus.req_a = 1'b1; bus.data_a = 16'h0123;
    bus.req_b = 1'b1; bus.data_b = 16'h0888;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    m_disp = '0;
    m_hold = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    steps(8);

    // Randomized traffic obeying the hold-until-grant rule.
    for (int i = 0; i < 400; i++) begin
      if (!bus.req_a && ($urandom % 3 == 0)) begin
        bus.req_a  = 1'b1;
        bus.data_a = 16'($urandom);
      end
      if (!bus.req_b && ($urandom % 7 == 0)) begin
        bus.req_b  = 1'b1;
        bus.data_b = 16'($urandom);
      end
      bus.clear = ($urandom % 15 == 0);
      step();
    end
    bus.clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
